fpcvt_pipe: RTL and testbench

FPCVT_PIPE -- requirements
Module: fpcvt_pipe

---
 rtl/fpcvt_pipe.sv | 171 +++++++++++++++++
 tb/tb_fpcvt_pipe.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fpcvt_pipe.sv
// Three-stage two's-complement to small-float converter with valid/ready flow control.
// Define FPCVT_OVF_EN to add the registered OVF saturation flag output.
module fpcvt_pipe #(
  parameter int DATA_W = 12,
  parameter int EXP_W  = 3,
  parameter int MANT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] D,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              S,
  output logic [EXP_W-1:0]  E,
  output logic [MANT_W-1:0] F
`ifdef FPCVT_OVF_EN
  ,
  output logic              OVF
`endif
);

  localparam int LZ_W = $clog2(DATA_W + 1);
  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MAG_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] ONE_D    = {{(DATA_W-1){1'b0}}, 1'b1};
  localparam logic [LZ_W-1:0]   ONE_LZ   = {{(LZ_W-1){1'b0}}, 1'b1};
  localparam logic [LZ_W-1:0]   EXP_SPAN = LZ_W'(2**EXP_W);
  localparam logic [EXP_W-1:0]  E_ONES   = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0]  E_ONE    = {{(EXP_W-1){1'b0}}, 1'b1};
  localparam logic [MANT_W-1:0] F_ONES   = {MANT_W{1'b1}};
  localparam logic [MANT_W-1:0] F_ONE    = {{(MANT_W-1){1'b0}}, 1'b1};
  localparam logic [MANT_W-1:0] F_HALF   = {1'b1, {(MANT_W-1){1'b0}}};

  logic              advance_s;
  logic              v1_q, s1_q, sat1_q;
  logic [DATA_W-1:0] mag1_q;
  logic              s1_d, sat1_d;
  logic [DATA_W-1:0] mag1_d;
  logic              v2_q, s2_q, sat2_q, r2_q;
  logic [EXP_W-1:0]  e2_q;
  logic [MANT_W-1:0] f2_q;
  logic              r2_d;
  logic [EXP_W-1:0]  e2_d;
  logic [MANT_W-1:0] f2_d;
  logic [LZ_W-1:0]   lz_s, diff_s;
  logic              out_valid_q, s3_q, sat3_q;
  logic [EXP_W-1:0]  e3_q, e3_d;
  logic [MANT_W-1:0] f3_q, f3_d;
  logic              sat3_d;

  // A stalled output freezes the whole pipe, bubbles included.
  assign advance_s = !out_valid_q || out_ready;
  assign in_ready  = advance_s;
  assign out_valid = out_valid_q;
  assign S         = s3_q;
  assign E         = e3_q;
  assign F         = f3_q;
`ifdef FPCVT_OVF_EN
  assign OVF       = sat3_q;
`endif

  // Stage 1: sign/magnitude; the most-negative input clamps and marks saturation.
  always_comb begin
    s1_d   = D[DATA_W-1];
    sat1_d = 1'b0;
    mag1_d = D;
    if (D == MOST_NEG) begin
      sat1_d = 1'b1;
      mag1_d = MAG_MAX;
    end else if (D[DATA_W-1]) begin
      mag1_d = ~D + ONE_D;
    end else begin
      mag1_d = D;
    end
  end

  // Stage 2: leading-zero count, then the exponent doubles as the right-shift amount.
  always_comb begin
    lz_s = LZ_W'(DATA_W);
    for (int i = 0; i < DATA_W; i++) begin
      if (mag1_q[i]) begin
        lz_s = LZ_W'(DATA_W - 1 - i);
      end else begin
        lz_s = lz_s;
      end
    end
    diff_s = EXP_SPAN - lz_s;
    if (lz_s >= EXP_SPAN) begin
      e2_d = {EXP_W{1'b0}};
      f2_d = mag1_q[MANT_W-1:0];
      r2_d = 1'b0;
    end else begin
      e2_d = diff_s[EXP_W-1:0];
      f2_d = MANT_W'(mag1_q >> diff_s);
      r2_d = ((mag1_q >> (diff_s - ONE_LZ)) & ONE_D) != {DATA_W{1'b0}};
    end
  end

  // Stage 3: round half-up with mantissa carry into the exponent, saturating at the top.
  always_comb begin
    e3_d   = e2_q;
    f3_d   = f2_q;
    sat3_d = 1'b0;
    if (sat2_q) begin
      sat3_d = 1'b1;
    end else if (r2_q) begin
      if (f2_q != F_ONES) begin
        f3_d = f2_q + F_ONE;
      end else if (e2_q != E_ONES) begin
        f3_d = F_HALF;
        e3_d = e2_q + E_ONE;
      end else begin
        sat3_d = 1'b1;
      end
    end else begin
      sat3_d = 1'b0;
    end
    if (sat3_d) begin
      e3_d = E_ONES;
      f3_d = F_ONES;
    end else begin
      e3_d = e3_d;
    end
  end

  // Pipeline registers; payloads load only behind a valid bit so idle inputs are never sampled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q        <= 1'b0;
      s1_q        <= 1'b0;
      sat1_q      <= 1'b0;
      mag1_q      <= {DATA_W{1'b0}};
      v2_q        <= 1'b0;
      s2_q        <= 1'b0;
      sat2_q      <= 1'b0;
      r2_q        <= 1'b0;
      e2_q        <= {EXP_W{1'b0}};
      f2_q        <= {MANT_W{1'b0}};
      out_valid_q <= 1'b0;
      s3_q        <= 1'b0;
      sat3_q      <= 1'b0;
      e3_q        <= {EXP_W{1'b0}};
      f3_q        <= {MANT_W{1'b0}};
    end else if (advance_s) begin
      v1_q        <= in_valid;
      v2_q        <= v1_q;
      out_valid_q <= v2_q;
      if (in_valid) begin
        s1_q   <= s1_d;
        sat1_q <= sat1_d;
        mag1_q <= mag1_d;
      end
      if (v1_q) begin
        s2_q   <= s1_q;
        sat2_q <= sat1_q;
        r2_q   <= r2_d;
        e2_q   <= e2_d;
        f2_q   <= f2_d;
      end
      if (v2_q) begin
        s3_q   <= s2_q;
        sat3_q <= sat3_d;
        e3_q   <= e3_d;
        f3_q   <= f3_d;
      end
    end
  end

endmodule

// File: tb/tb_fpcvt_pipe.sv
// Scoreboard bench for fpcvt_pipe: directed vectors, stall/order, reset flush, full input sweep.
module tb_fpcvt_pipe;

  typedef struct packed {
    logic       s;
    logic [2:0] e;
    logic [3:0] f;
    logic       ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, S;
  logic [11:0] D;
  logic [2:0]  E;
  logic [3:0]  F;
`ifdef FPCVT_OVF_EN
  logic        OVF;
`endif

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  fpcvt_pipe #(.DATA_W(12), .EXP_W(3), .MANT_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .D(D),
    .out_valid(out_valid), .out_ready(out_ready), .S(S), .E(E), .F(F)
`ifdef FPCVT_OVF_EN
    , .OVF(OVF)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic s, input int e, input int f, input logic ovf);
    exp_t x;
    x.s = s; x.e = 3'(e); x.f = 4'(f); x.ovf = ovf;
    return x;
  endfunction

  // Independent arithmetic model: shift the magnitude down until it fits in 4 bits.
  function automatic exp_t model(input logic [11:0] d);
    int mag, e, f;
    logic s;
    s   = d[11];
    mag = d[11] ? 4096 - int'(d) : int'(d);
    if (mag >= 2048) return mk(s, 7, 15, 1'b1);
    e = 0;
    while ((mag >> e) >= 16) e++;
    f = mag >> e;
    if (e > 0 && ((mag >> (e - 1)) & 1) == 1) begin
      f++;
      if (f == 16) begin f = 8; e++; end
    end
    if (e > 7) return mk(s, 7, 15, 1'b1);
    return mk(s, e, f, 1'b0);
  endfunction

  task automatic send(input logic [11:0] d, input exp_t x);
    int tries = 0;
    D = d; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && tries < 50) begin @(negedge clk); tries++; end
    if (!in_ready) chk("accept_timeout", {31'd0, in_ready}, 32'd1);
    else sb_q.push_back(x);
    @(posedge clk); #1;
    in_valid = 1'b0; D = 12'hA5A;
  endtask

  task automatic latency_chk(input string name);
    int cyc = 1;
    while (!out_valid && cyc < 10) begin @(posedge clk); #1; cyc++; end
    chk(name, cyc, 32'd3);
  endtask

  task automatic drain();
    int cyc = 0;
    while ((sb_q.size() != 0 || out_valid) && cyc < 100) begin @(posedge clk); #1; cyc++; end
    chk("drain_queue", sb_q.size(), 32'd0);
  endtask

  // Monitor: pops the scoreboard on every output handshake and checks stall stability.
  initial begin
    logic       stalled = 1'b0;
    logic [8:0] held = 9'd0;
    exp_t       x;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 1'b0;
      end else begin
        chk("in_ready", {31'd0, in_ready}, {31'd0, (!out_valid || out_ready)});
        if (stalled) chk("stall_hold", {23'd0, out_valid, S, E, F}, {23'd0, held});
        stalled = out_valid && !out_ready;
        held    = {out_valid, S, E, F};
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_out", {31'd0, out_valid}, 32'd0);
          end else begin
            x = sb_q.pop_front();
            chk("S", {31'd0, S}, {31'd0, x.s});
            chk("E", {29'd0, E}, {29'd0, x.e});
            chk("F", {28'd0, F}, {28'd0, x.f});
`ifdef FPCVT_OVF_EN
            chk("OVF", {31'd0, OVF}, {31'd0, x.ovf});
`endif
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; D = 12'h000;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_SEF", {24'd0, S, E, F}, 32'd0);
`ifdef FPCVT_OVF_EN
    chk("rst_OVF", {31'd0, OVF}, 32'd0);
`endif
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;

    // Zero with measured latency on an empty pipe.
    send(12'h000, mk(1'b0, 0, 0, 1'b0));
    latency_chk("latency_zero");
    drain();

    // Hand-computed directed vectors, back to back.
    send(12'h1A6, mk(1'b0, 5, 13, 1'b0));
    send(12'h07D, mk(1'b0, 4, 8, 1'b0));
    send(12'h7FF, mk(1'b0, 7, 15, 1'b1));
    send(12'h800, mk(1'b1, 7, 15, 1'b1));
    send(12'hFFF, mk(1'b1, 0, 1, 1'b0));
    send(12'h00F, mk(1'b0, 0, 15, 1'b0));
    send(12'h010, mk(1'b0, 1, 8, 1'b0));
    send(12'h01F, mk(1'b0, 2, 8, 1'b0));
    send(12'hF83, mk(1'b1, 4, 8, 1'b0));
    send(12'h7F7, mk(1'b0, 7, 15, 1'b1));
    send(12'h7BF, mk(1'b0, 7, 15, 1'b0));
    send(12'h3FF, mk(1'b0, 7, 8, 1'b0));
    drain();

    // Stream of 8 with out_ready toggling 1,0,0.
    fork
      begin
        send(12'h001, mk(1'b0, 0, 1, 1'b0));
        send(12'h1A6, mk(1'b0, 5, 13, 1'b0));
        send(12'h07D, mk(1'b0, 4, 8, 1'b0));
        send(12'hFFF, mk(1'b1, 0, 1, 1'b0));
        send(12'h020, mk(1'b0, 2, 8, 1'b0));
        send(12'h800, mk(1'b1, 7, 15, 1'b1));
        send(12'h00A, mk(1'b0, 0, 10, 1'b0));
        send(12'h3FF, mk(1'b0, 7, 8, 1'b0));
      end
      begin
        for (int i = 0; i < 45; i++) begin
          @(posedge clk); #1;
          out_ready = (i % 3 == 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three samples in flight.
    send(12'h1A6, mk(1'b0, 5, 13, 1'b0));
    send(12'h07D, mk(1'b0, 4, 8, 1'b0));
    send(12'h7FF, mk(1'b0, 7, 15, 1'b1));
    rst = 1'b1;
    @(negedge clk);
    chk("rst_flush_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_flush_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_flush_SEF", {24'd0, S, E, F}, 32'd0);
    sb_q.delete();
    @(posedge clk); #1; rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_stale_out", {31'd0, out_valid}, 32'd0);
    end
    @(posedge clk); #1;
    send(12'h07D, mk(1'b0, 4, 8, 1'b0));
    latency_chk("latency_after_rst");
    drain();

    // Full sweep against the arithmetic model.
    for (int i = 0; i < 4096; i++) send(12'(i), model(12'(i)));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
